// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - branch lookup table bus between sequencer and LUT
//
// Purpose: bundles the branch LUT request/response signals.
//   lut_en   master->slave  lookup enable
//   lut_key  master->slave  branch label key (0 while lut_en is low)
//   lut_pos  slave->master  absolute target, combinational from lut_en/lut_key;
//                           0 means the key is unmapped
interface pc_sequencer_if #(
  parameter int PC_W  = 12,
  parameter int KEY_W = 5
);
  logic             lut_en;
  logic [KEY_W-1:0] lut_key;
  logic [PC_W-1:0]  lut_pos;

  modport master (output lut_en, output lut_key, input lut_pos);
  modport slave  (input lut_en, input lut_key, output lut_pos);
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with LUT branch redirect
//
// Purpose: sequences instruction fetch for the single-cycle core, resolves
// taken branches through the branch LUT, inserts a one-cycle redirect bubble
// on each taken branch and tracks done/error/cycle-count status.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            pulse, (re)starts execution at START_PC from IDLE/DONE
//   stall            holds pc in RUN (branch/halt ignored while stalled)
//   br_req, br_key   taken branch and its label key
//   halt             halt/done instruction
//   lut              branch LUT bus (master side)
//   pc, fetch_valid  fetch address and its validity
//   flush            squash the instruction in decode (redirect cycle)
//   done             program finished
//   err              sticky: bit0 unmapped key, bit1 pc overflow
//   cycle_count      saturating count of RUN + REDIRECT cycles
module pc_sequencer #(
  parameter int PC_W     = 12,
  parameter int KEY_W    = 5,
  parameter int START_PC = 0,
  parameter int MAX_PC   = 4095,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              br_req,
  input  logic [KEY_W-1:0]  br_key,
  input  logic              halt,
  pc_sequencer_if.master    lut,
  output logic [PC_W-1:0]   pc,
  output logic              fetch_valid,
  output logic              flush,
  output logic              done,
  output logic [1:0]        err,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REDIRECT, S_DONE} state_e;

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);
  localparam logic [PC_W-1:0] LAST_ADDR  = PC_W'(MAX_PC);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             br_take;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_ADDR;
      err_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating cycle counter increment
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          err_d   = 2'b00;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (!stall) begin
          if (halt) begin
            state_d = S_DONE;
          end else if (br_req) begin
            // A zero target is the LUT's "no such label" answer.
            if (lut.lut_pos != '0) begin
              pc_d    = lut.lut_pos;
              state_d = S_REDIRECT;
            end else begin
              err_d[0] = 1'b1;
              state_d  = S_DONE;
            end
          end else if (pc_q == LAST_ADDR) begin
            err_d[1] = 1'b1;
            state_d  = S_DONE;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      S_REDIRECT: begin
        cnt_d   = cnt_inc;
        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fetch_valid = (state_q == S_RUN);
    flush       = (state_q == S_REDIRECT);
    done        = (state_q == S_DONE);
    // The LUT is only consulted when the branch will actually be acted on.
    br_take     = (state_q == S_RUN) && !stall && !halt && br_req;
    lut.lut_en  = br_take;
    lut.lut_key = br_take ? br_key : '0;
  end

  assign pc          = pc_q;
  assign err         = err_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;
  localparam int PC_W  = 12;
  localparam int KEY_W = 5;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Branch LUT contents: keys 0 and 7 unmapped, others map to key+13.
  function automatic logic [PC_W-1:0] lut_fn(input logic [KEY_W-1:0] k);
    if (k == 5'd0 || k == 5'd7) return '0;
    return PC_W'(k) + PC_W'(13);
  endfunction

  // ---------------- DUT A: default parameters ----------------
  logic             rst_n, start, stall, br_req, halt;
  logic [KEY_W-1:0] br_key;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid, flush, done;
  logic [1:0]       err;
  logic [CNT_W-1:0] cycle_count;

  pc_sequencer_if #(.PC_W(PC_W), .KEY_W(KEY_W)) lut_a ();
  assign lut_a.lut_pos = lut_a.lut_en ? lut_fn(lut_a.lut_key) : '0;

  pc_sequencer #(.PC_W(PC_W), .KEY_W(KEY_W), .START_PC(0), .MAX_PC(4095), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .br_req(br_req),
    .br_key(br_key), .halt(halt), .lut(lut_a.master), .pc(pc),
    .fetch_valid(fetch_valid), .flush(flush), .done(done), .err(err),
    .cycle_count(cycle_count)
  );

  // ---------------- DUT B: MAX_PC=7, 4-bit counter ----------------
  logic             b_rst_n, b_start, b_stall;
  logic             b_zero = 1'b0;
  logic [KEY_W-1:0] b_key = '0;
  logic [PC_W-1:0]  b_pc;
  logic             b_fv, b_flush, b_done;
  logic [1:0]       b_err;
  logic [3:0]       b_cnt;

  pc_sequencer_if #(.PC_W(PC_W), .KEY_W(KEY_W)) lut_b ();
  assign lut_b.lut_pos = '0;

  pc_sequencer #(.PC_W(PC_W), .KEY_W(KEY_W), .START_PC(0), .MAX_PC(7), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .stall(b_stall), .br_req(b_zero),
    .br_key(b_key), .halt(b_zero), .lut(lut_b.master), .pc(b_pc),
    .fetch_valid(b_fv), .flush(b_flush), .done(b_done), .err(b_err),
    .cycle_count(b_cnt)
  );

  // ---------------- Behavioural model of DUT A ----------------
  bit              m_active = 1'b0;  // executing (fetching or in a bubble)
  bit              m_bubble = 1'b0;  // cycle after a taken branch
  bit              m_done   = 1'b0;
  logic [PC_W-1:0] m_pc     = '0;
  logic [1:0]      m_err    = 2'b00;
  int              m_cnt    = 0;
  int              cnt_max  = (1 << CNT_W) - 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_bubble <= 1'b0; m_done <= 1'b0;
      m_pc <= '0; m_err <= 2'b00; m_cnt <= 0;
    end else if (m_active) begin
      m_cnt <= (m_cnt < cnt_max) ? m_cnt + 1 : m_cnt;
      if (m_bubble) begin
        m_bubble <= 1'b0;
      end else if (!stall) begin
        if (halt) begin
          m_active <= 1'b0; m_done <= 1'b1;
        end else if (br_req) begin
          if (lut_fn(br_key) != 0) begin
            m_pc <= lut_fn(br_key); m_bubble <= 1'b1;
          end else begin
            m_err[0] <= 1'b1; m_active <= 1'b0; m_done <= 1'b1;
          end
        end else if (m_pc == 4095) begin
          m_err[1] <= 1'b1; m_active <= 1'b0; m_done <= 1'b1;
        end else begin
          m_pc <= m_pc + 1;
        end
      end
    end else if (start) begin
      m_active <= 1'b1; m_done <= 1'b0; m_bubble <= 1'b0;
      m_pc <= '0; m_err <= 2'b00; m_cnt <= 0;
    end
  end

  // Per-cycle comparison of DUT A against the model, mid-cycle.
  always @(negedge clk) begin
    logic exp_lut_en;
    exp_lut_en = m_active && !m_bubble && !stall && !halt && br_req;
    chk("m_pc", 32'(pc), 32'(m_pc));
    chk("m_fetch_valid", 32'(fetch_valid), 32'(m_active && !m_bubble));
    chk("m_flush", 32'(flush), 32'(m_bubble));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_err", 32'(err), 32'(m_err));
    chk("m_cycle_count", 32'(cycle_count), 32'(m_cnt));
    chk("m_lut_en", 32'(lut_a.lut_en), 32'(exp_lut_en));
    chk("m_lut_key", 32'(lut_a.lut_key), exp_lut_en ? 32'(br_key) : 32'd0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; br_req = 1'b0; halt = 1'b0; br_key = '0;
    b_rst_n = 1'b0; b_start = 1'b0; b_stall = 1'b0;
    step(2);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(cycle_count), 32'd0);
    chk("rst_lut_key", 32'(lut_a.lut_key), 32'd0);
    rst_n = 1'b1; step(1);

    // Start and free-run
    pulse_start();
    chk("run_pc0", 32'(pc), 32'd0);
    chk("run_fv", 32'(fetch_valid), 32'd1);
    step(3);
    chk("run_pc3", 32'(pc), 32'd3);

    // Taken branch key 3 -> 16
    br_req = 1'b1; br_key = 5'd3; #1;
    chk("br_lut_en", 32'(lut_a.lut_en), 32'd1);
    chk("br_lut_key", 32'(lut_a.lut_key), 32'd3);
    step(1); br_req = 1'b0;
    chk("redir_pc", 32'(pc), 32'd16);
    chk("redir_flush", 32'(flush), 32'd1);
    chk("redir_fv", 32'(fetch_valid), 32'd0);
    step(1);
    chk("post_redir_pc", 32'(pc), 32'd16);
    chk("post_redir_fv", 32'(fetch_valid), 32'd1);
    step(1);
    chk("pc17", 32'(pc), 32'd17);
    chk("cnt6", 32'(cycle_count), 32'd6);

    // Unmapped key
    br_req = 1'b1; br_key = 5'd7; step(1); br_req = 1'b0;
    chk("unmap_done", 32'(done), 32'd1);
    chk("unmap_err", 32'(err), 32'd1);
    chk("unmap_pc", 32'(pc), 32'd17);
    step(2);
    chk("done_cnt_frozen", 32'(cycle_count), 32'd7);

    // Restart, stall together with branch
    pulse_start();
    chk("restart_err", 32'(err), 32'd0);
    step(7);
    stall = 1'b1; br_req = 1'b1; br_key = 5'd5; #1;
    chk("stall_lut_en", 32'(lut_a.lut_en), 32'd0);
    step(3);
    chk("stall_pc", 32'(pc), 32'd7);
    stall = 1'b0; #1;
    chk("unstall_lut_en", 32'(lut_a.lut_en), 32'd1);
    step(1); br_req = 1'b0;
    chk("stall_br_pc", 32'(pc), 32'd18);
    step(1);

    // start ignored in RUN
    pulse_start();
    chk("start_ignored", 32'(pc), 32'd19);
    halt = 1'b1; step(1); halt = 1'b0;

    // halt beats br_req
    pulse_start();
    step(9);
    halt = 1'b1; br_req = 1'b1; br_key = 5'd3; #1;
    chk("halt_lut_en", 32'(lut_a.lut_en), 32'd0);
    step(1); halt = 1'b0; br_req = 1'b0;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_pc", 32'(pc), 32'd9);
    chk("halt_err", 32'(err), 32'd0);
    pulse_start();
    chk("halt_restart_pc", 32'(pc), 32'd0);
    chk("halt_restart_cnt", 32'(cycle_count), 32'd0);

    // Reset in the middle of a redirect
    step(2);
    br_req = 1'b1; br_key = 5'd3; step(1); br_req = 1'b0;
    chk("pre_rst_flush", 32'(flush), 32'd1);
    rst_n = 1'b0; #1;
    chk("midrst_flush", 32'(flush), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_fv", 32'(fetch_valid), 32'd0);
    step(2);
    rst_n = 1'b1; step(1);

    // DUT B: counter saturation and pc overflow
    b_rst_n = 1'b1; step(1);
    b_start = 1'b1; step(1); b_start = 1'b0;
    b_stall = 1'b1; step(20);
    chk("b_sat_cnt", 32'(b_cnt), 32'd15);
    chk("b_stall_pc", 32'(b_pc), 32'd0);
    b_stall = 1'b0; step(7);
    chk("b_pc7", 32'(b_pc), 32'd7);
    chk("b_not_done", 32'(b_done), 32'd0);
    step(1);
    chk("b_ovf_done", 32'(b_done), 32'd1);
    chk("b_ovf_err", 32'(b_err), 32'd2);
    chk("b_ovf_pc", 32'(b_pc), 32'd7);
    chk("b_ovf_fv", 32'(b_fv), 32'd0);
    chk("b_flush", 32'(b_flush), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the single-cycle core. It sequences instruction fetch and owns the branch lookup table's enable and key.
- Resolves taken branches through the LUT into absolute targets and inserts a one-cycle redirect bubble on every taken branch.
- Tracks run/done status, error flags and cycle count for the testbench and top level.
- Sits between decode/ALU (branch and halt requests) and instruction memory (pc, fetch_valid).

Parameters:
- PC_W, 12, program counter width; must match the LUT's branch_pos width.
- KEY_W, 5, branch key width; must match the LUT's key width.
- START_PC, 0, PC loaded on start.
- MAX_PC, 4095, last legal instruction address.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins execution at START_PC.
- stall  in  1  holds pc in RUN.
- br_req  in  1  current instruction is a taken branch.
- br_key  in  KEY_W  branch label key of the current instruction.
- halt  in  1  current instruction is the halt/done instruction.
- lut_en  out  1  branch LUT enable.
- lut_key  out  KEY_W  branch LUT key.
- lut_pos  in  PC_W  LUT target, combinational from lut_en/lut_key.
- pc  out  PC_W  current fetch address.
- fetch_valid  out  1  pc holds a real instruction this cycle.
- flush  out  1  squash the instruction currently in decode.
- done  out  1  program finished, level.
- err  out  2  sticky error flags: bit0 = unmapped key, bit1 = pc overflow.
- cycle_count  out  CNT_W  cycles spent in RUN + REDIRECT, saturating.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, pc=START_PC, err=0, cycle_count=0.
  - done, flush, fetch_valid, lut_en all 0; lut_key=0.
  - Reset asserted mid-run aborts immediately. No pending redirect survives.
- States: IDLE, RUN, REDIRECT, DONE.
- IDLE:
  - fetch_valid=0.
  - start -> RUN; pc<=START_PC, cycle_count<=0, err<=0.
- RUN:
  - fetch_valid=1; cycle_count increments every cycle, including stalled cycles.
  - Request priority: halt > br_req > increment.
  - stall=1: pc holds. br_req and halt are ignored, and lut_en=0.
  - halt (stall=0): -> DONE; pc holds.
  - br_req (stall=0):
    - lut_en=1 and lut_key=br_key combinationally in the same cycle.
    - If lut_pos!=0: pc<=lut_pos, -> REDIRECT.
    - If lut_pos==0: unmapped key. err[0]<=1, -> DONE, pc holds.
  - Otherwise (stall=0): increment.
    - If pc==MAX_PC: err[1]<=1, -> DONE, pc holds.
    - Else pc<=pc+1 (PC_W-bit unsigned).
- REDIRECT:
  - Exactly one cycle; flush=1, fetch_valid=0; -> RUN unconditionally. stall is ignored here.
  - cycle_count increments. br_req and halt are ignored; lut_en=0.
- DONE:
  - done=1, fetch_valid=0; pc and err hold; cycle_count frozen.
  - start -> RUN with the same reload as from IDLE.
- lut_key=0 whenever lut_en=0.
- start is ignored in RUN and REDIRECT.
- cycle_count saturates at all-ones.
- flush is high only in REDIRECT.
- done is high only in DONE.

Test Plan:
- Reset then start; hold stall=0 with no requests for 5 cycles -> pc 0,1,2,3,4, fetch_valid=1, cycle_count=5.
- At pc=3 assert br_req with br_key=5'b00011 and LUT returning 16 -> lut_en=1 and lut_key=3 that cycle. Next cycle: pc=16, flush=1, fetch_valid=0. Following cycle: pc=16, fetch_valid=1, then 17.
- br_req with key 5'b00111 (LUT returns 0) -> DONE next cycle, err=2'b01, done=1, pc unchanged.
- At pc=7 assert stall together with br_req for 3 cycles -> pc stays 7 and lut_en=0 throughout. On releasing stall with br_req still high, the branch is taken.
- halt and br_req asserted together at pc=9 -> DONE, lut_en=0, pc=9, err=0. A start pulse then restarts with pc=0 and cycle_count=0.
- MAX_PC=7: run to pc=7 with no branch -> DONE with err=2'b10. Dropping rst_n mid-REDIRECT -> IDLE immediately, flush=0, pc=START_PC.
